// File: rtl/truth_table_sweep_ctrl_if.sv
// Handshake/data bundle between the sweep sequencer and its test/config + counter/F side.
// Optional compare signals exist only when SWEEP_COMPARE_EN is defined.
interface truth_table_sweep_ctrl_if #(
    parameter int CNT_W = 4
) ();
    localparam int N = 2 ** CNT_W;

    logic             start;
    logic             f_in;
    logic             clr;
    logic             inc;
    logic [CNT_W-1:0] code;
    logic             busy;
    logic             done;
    logic [N-1:0]     table_out;
`ifdef SWEEP_COMPARE_EN
    logic [N-1:0]     expected;
    logic             mismatch;
    logic [CNT_W-1:0] mismatch_idx;

    modport master (
        output start, f_in, expected,
        input  clr, inc, code, busy, done, table_out, mismatch, mismatch_idx
    );
    modport slave (
        input  start, f_in, expected,
        output clr, inc, code, busy, done, table_out, mismatch, mismatch_idx
    );
`else
    modport master (
        output start, f_in,
        input  clr, inc, code, busy, done, table_out
    );
    modport slave (
        input  start, f_in,
        output clr, inc, code, busy, done, table_out
    );
`endif
endinterface

// File: rtl/truth_table_sweep_ctrl.sv
// Sweeps the external event counter through every code, samples F into a truth table.
// Define SWEEP_COMPARE_EN to add golden-table compare (expected/mismatch/mismatch_idx).
//
//   state    | meaning
//   ---------+----------------------------------------------
//   S_IDLE   | waiting for start
//   S_CLEAR  | clr pulse, code reset, settle counter loaded
//   S_SETTLE | counting down the settle window
//   S_SAMPLE | table_out[code] <= f_in
//   S_STEP   | inc pulse, code advanced, settle reloaded
//   S_DONE   | one-cycle done pulse
module truth_table_sweep_ctrl #(
    parameter int CNT_W  = 4,
    parameter int SETTLE = 2
) (
    input  logic                     clk,
    input  logic                     reset_n,
    truth_table_sweep_ctrl_if.slave  bus
);
    localparam int N  = 2 ** CNT_W;
    localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [SW-1:0]    SETTLE_LOAD = SW'(SETTLE - 1);
    localparam logic [CNT_W-1:0] LAST_CODE   = CNT_W'(N - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_SETTLE,
        S_SAMPLE,
        S_STEP,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [SW-1:0]    r_settle;
    logic [CNT_W-1:0] r_code;
    logic [N-1:0]     r_table;
    logic             r_clr;
    logic             r_inc;
    logic             r_busy;
    logic             r_done;
    logic             w_last;

    assign w_last = (r_code == LAST_CODE);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (bus.start) w_next = S_CLEAR;
            S_CLEAR:  w_next = S_SETTLE;
            S_SETTLE: if (r_settle == '0) w_next = S_SAMPLE;
            S_SAMPLE: w_next = w_last ? S_DONE : S_STEP;
            S_STEP:   w_next = S_SETTLE;
            S_DONE:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // Pulse/status outputs are registered from the next state so they line up with the state itself.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= S_IDLE;
            r_clr    <= 1'b0;
            r_inc    <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_code   <= '0;
            r_settle <= '0;
            r_table  <= '0;
        end else begin
            r_state <= w_next;
            r_clr   <= (w_next == S_CLEAR);
            r_inc   <= (w_next == S_STEP);
            r_busy  <= (w_next != S_IDLE);
            r_done  <= (w_next == S_DONE);
            case (r_state)
                S_CLEAR: begin
                    r_code   <= '0;
                    r_settle <= SETTLE_LOAD;
                end
                S_SETTLE: if (r_settle != '0) r_settle <= r_settle - 1'b1;
                S_SAMPLE: r_table[r_code] <= bus.f_in;
                S_STEP: begin
                    r_code   <= r_code + 1'b1;
                    r_settle <= SETTLE_LOAD;
                end
                default: ;
            endcase
        end
    end

    assign bus.clr       = r_clr;
    assign bus.inc       = r_inc;
    assign bus.code      = r_code;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.table_out = r_table;

`ifdef SWEEP_COMPARE_EN
    logic [N-1:0]     r_expected;
    logic             r_mismatch;
    logic [CNT_W-1:0] r_mismatch_idx;
    logic [N-1:0]     w_final;
    logic [N-1:0]     w_diff;
    logic [CNT_W-1:0] w_low_idx;

    // The last table bit is still being written in the final SAMPLE, so fold it in here.
    always_comb begin
        w_final         = r_table;
        w_final[r_code] = bus.f_in;
        w_diff          = w_final ^ r_expected;
        w_low_idx       = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (w_diff[i]) w_low_idx = CNT_W'(i);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_expected     <= '0;
            r_mismatch     <= 1'b0;
            r_mismatch_idx <= '0;
        end else if (r_state == S_IDLE && bus.start) begin
            r_expected     <= bus.expected;
            r_mismatch     <= 1'b0;
            r_mismatch_idx <= '0;
        end else if (r_state == S_SAMPLE && w_last) begin
            r_mismatch     <= |w_diff;
            r_mismatch_idx <= w_low_idx;
        end
    end

    assign bus.mismatch     = r_mismatch;
    assign bus.mismatch_idx = r_mismatch_idx;
`endif
endmodule

// File: tb/tb_truth_table_sweep_ctrl.sv
// Randomized self-checking bench for truth_table_sweep_ctrl with an external counter + F model.
`timescale 1ns/1ps
module tb_truth_table_sweep_ctrl;
    localparam int CNT_W  = 4;
    localparam int SETTLE = 2;
    localparam int N      = 2 ** CNT_W;
    localparam int LAT    = 1 + N * (SETTLE + 1) + (N - 1);

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    truth_table_sweep_ctrl_if #(.CNT_W(CNT_W)) bus ();

    truth_table_sweep_ctrl #(.CNT_W(CNT_W), .SETTLE(SETTLE)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic f_model(input logic [3:0] c);
        logic a, b, cc, d;
        {a, b, cc, d} = c;
        return (b | ~d) ? ((a & d) | cc) : (a & ~cc);
    endfunction

    // External 4-bit event counter feeding F; the function under test is a lookup in f_src.
    logic [CNT_W-1:0] m_cnt;
    logic [N-1:0]     f_src = '0;
    int n_clr  = 0;
    int n_inc  = 0;
    int n_done = 0;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n)    m_cnt <= '0;
        else if (bus.clr) m_cnt <= '0;
        else if (bus.inc) m_cnt <= m_cnt + 1'b1;
    end

    always @(posedge clk) begin
        if (bus.clr)  n_clr++;
        if (bus.inc)  n_inc++;
        if (bus.done) n_done++;
    end

    assign bus.f_in = f_src[m_cnt];

    task automatic sweep(input string tag, input logic [N-1:0] src, input logic [N-1:0] exp_tbl,
                         input logic [N-1:0] golden, input bit glitch);
        int  c0, i0, d0, lat;
        bit  seen, glitched;
        c0 = n_clr; i0 = n_inc; d0 = n_done;
        @(negedge clk);
        f_src = src;
`ifdef SWEEP_COMPARE_EN
        bus.expected = golden;
`endif
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        lat = 0; seen = 0; glitched = 0;
        while (!seen && lat < 200) begin
            @(posedge clk);
            #1 lat++;
            bus.start = 1'b0;
            if (bus.done) seen = 1;
            else if (glitch && !glitched && bus.busy && bus.code == 4'd5) begin
                bus.start = 1'b1;
                glitched  = 1;
            end
        end
        bus.start = 1'b0;
        chk({tag, "_done_seen"}, 32'(seen), 32'd1);
        chk({tag, "_latency"}, 32'(lat), 32'(LAT));
        chk({tag, "_table"}, 32'(bus.table_out), 32'(exp_tbl));
        chk({tag, "_clr_cnt"}, 32'(n_clr - c0), 32'd1);
        chk({tag, "_inc_cnt"}, 32'(n_inc - i0), 32'(N - 1));
`ifdef SWEEP_COMPARE_EN
        begin
            logic [N-1:0] diff;
            int           idx;
            diff = exp_tbl ^ golden;
            idx  = 0;
            for (int i = 0; i < N; i++) if (diff[i] && idx == 0 && diff[idx] == 1'b0) idx = i;
            chk({tag, "_mismatch"}, 32'(bus.mismatch), 32'(diff != '0));
            chk({tag, "_mismatch_idx"}, 32'(bus.mismatch_idx), 32'(idx));
        end
`endif
        repeat (3) @(posedge clk);
        #1;
        chk({tag, "_done_cnt"}, 32'(n_done - d0), 32'd1);
        chk({tag, "_busy_after"}, 32'(bus.busy), 32'd0);
        chk({tag, "_table_hold"}, 32'(bus.table_out), 32'(exp_tbl));
    endtask

    logic [N-1:0] f_tbl;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start = 1'b0;
`ifdef SWEEP_COMPARE_EN
        bus.expected = '0;
`endif
        for (int i = 0; i < N; i++) f_tbl[i] = f_model(4'(i));

        // Reset held with start asserted: nothing may move.
        repeat (2) @(posedge clk);
        @(negedge clk) bus.start = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_clr", 32'(bus.clr), 32'd0);
        chk("rst_inc", 32'(bus.inc), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_code", 32'(bus.code), 32'd0);
        chk("rst_table", 32'(bus.table_out), 32'd0);
`ifdef SWEEP_COMPARE_EN
        chk("rst_mismatch", 32'(bus.mismatch), 32'd0);
        chk("rst_mismatch_idx", 32'(bus.mismatch_idx), 32'd0);
`endif
        @(negedge clk);
        bus.start = 1'b0;
        reset_n   = 1'b1;
        repeat (2) @(posedge clk);

        sweep("modelF", f_tbl, 16'hE6C4, 16'hE6C4, 0);
        sweep("ones", 16'hFFFF, 16'hFFFF, 16'hFFFF, 0);
        sweep("zeros", 16'h0000, 16'h0000, 16'h0000, 0);
        sweep("busy_start", f_tbl, 16'hE6C4, 16'hE6C4, 1);

        // Mid-sweep reset: partial table discarded, no done pulse.
        begin
            int d0, n;
            d0 = n_done;
            @(negedge clk);
            f_src = f_tbl;
            bus.start = 1'b1;
            @(posedge clk);
            #1 bus.start = 1'b0;
            n = 0;
            while (bus.code != 4'd9 && n < 200) begin
                @(posedge clk);
                #1 n++;
            end
            chk("midrst_reach9", 32'(bus.code), 32'd9);
            reset_n = 1'b0;
            #1;
            chk("midrst_table", 32'(bus.table_out), 32'd0);
            chk("midrst_busy", 32'(bus.busy), 32'd0);
            chk("midrst_code", 32'(bus.code), 32'd0);
            repeat (3) @(posedge clk);
            @(negedge clk) reset_n = 1'b1;
            repeat (3) @(posedge clk);
            #1;
            chk("midrst_no_done", 32'(n_done - d0), 32'd0);
            chk("midrst_idle_busy", 32'(bus.busy), 32'd0);
        end
        sweep("after_rst", f_tbl, 16'hE6C4, 16'hE6C4, 0);

        sweep("cmp_bad", f_tbl, 16'hE6C4, 16'hE6C5, 0);
        sweep("cmp_good", f_tbl, 16'hE6C4, 16'hE6C4, 0);

        for (int r = 0; r < 6; r++) begin
            logic [N-1:0] src, gold;
            src  = N'($urandom);
            gold = ($urandom_range(0, 1) == 1) ? src : (src ^ N'(1 << $urandom_range(0, N - 1)));
            sweep($sformatf("rand%0d", r), src, src, gold, bit'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
